mem_hazard_unit: RTL and testbench



---
 rtl/mem_hazard_unit_pkg.sv | 29 ++
 rtl/mem_hazard_unit_hazard_match.sv | 15 +
 rtl/mem_hazard_unit.sv | 141 ++++++++++++++
 tb/tb_mem_hazard_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_hazard_unit_pkg.sv
// Shared types for the MIPS32 hazard/forwarding unit: forward-select codes,
// FSM states and the shadow record carried for each in-flight instruction.
package mem_hazard_unit_pkg;

  // Records are sized for the widest register number supported; narrower
  // register numbers are zero-extended on entry.
  localparam int REG_W_MAX = 8;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } hz_state_t;

  typedef struct packed {
    logic                 regwrite;
    logic                 memread;
    logic                 memwrite;
    logic [REG_W_MAX-1:0] wreg;
    logic [REG_W_MAX-1:0] rs;
    logic [REG_W_MAX-1:0] rt;
    logic                 use_rs;
    logic                 use_rt;
  } shadow_rec_t;

endpackage

// File: rtl/mem_hazard_unit_hazard_match.sv
// Register-dependence compare: a live producer writing a non-zero register
// that a consumer actually reads.
module hazard_match #(
  parameter int W = 8
) (
  input  logic         vld,
  input  logic [W-1:0] wreg,
  input  logic [W-1:0] src,
  input  logic         use_src,
  output logic         match
);

  assign match = vld && use_src && (wreg != '0) && (wreg == src);

endmodule

// File: rtl/mem_hazard_unit.sv
// Load-use stall control and EX/MEM forwarding selects for the 5-stage
// pipeline, driven from shadow copies of the EX, MEM and WB instructions.
module mem_hazard_unit
  import mem_hazard_unit_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int COUNT_W    = 16
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  Valid_ID,
  input  logic [REG_ADDR_W-1:0] Rs_ID,
  input  logic [REG_ADDR_W-1:0] Rt_ID,
  input  logic                  Uses_Rs_ID,
  input  logic                  Uses_Rt_ID,
  input  logic                  MemRead_ID,
  input  logic                  MemWrite_ID,
  input  logic                  RegWrite_ID,
  input  logic [REG_ADDR_W-1:0] Write_Reg_ID,
  input  logic                  Flush_ID,
  output logic                  Stall_IF_ID,
  output logic                  Bubble_ID_EX,
  output logic [1:0]            Forward_A_EX,
  output logic [1:0]            Forward_B_EX,
  output logic                  Forward_Mem_to_Mem,
  output logic [COUNT_W-1:0]    Stall_Count
);

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (&v) ? v : v + COUNT_W'(1);
  endfunction

  // _p0 = EX, _p1 = MEM, _p2 = WB
  shadow_rec_t rec_p0, rec_p1, rec_p2;
  logic        vld_p0, vld_p1, vld_p2;
  shadow_rec_t id_rec;
  logic        id_live, id_vld;

  hz_state_t   state, state_nxt;
  logic        rs_hit, rt_hit, hazard;
  logic        a_mem, a_wb, b_mem, b_wb, m2m_hit;
  logic [1:0]  fwd_a_nxt, fwd_b_nxt;

  assign id_rec = '{
    regwrite: RegWrite_ID,
    memread:  MemRead_ID,
    memwrite: MemWrite_ID,
    wreg:     REG_W_MAX'(Write_Reg_ID),
    rs:       REG_W_MAX'(Rs_ID),
    rt:       REG_W_MAX'(Rt_ID),
    use_rs:   Uses_Rs_ID,
    use_rt:   Uses_Rt_ID
  };

  assign id_live = Valid_ID && !Flush_ID;

  // Load in EX against the ID sources
  hazard_match #(.W(REG_W_MAX)) u_lu_rs (
    .vld(vld_p0 && rec_p0.memread), .wreg(rec_p0.wreg), .src(id_rec.rs),
    .use_src(id_live && Uses_Rs_ID), .match(rs_hit)
  );
  hazard_match #(.W(REG_W_MAX)) u_lu_rt (
    .vld(vld_p0 && rec_p0.memread), .wreg(rec_p0.wreg), .src(id_rec.rt),
    .use_src(id_live && Uses_Rt_ID), .match(rt_hit)
  );

  // A store whose only dependence is its data register picks the value up
  // in MEM through the mem-to-mem path instead of stalling.
  assign hazard       = Reset_n && (state == RUN) && (rs_hit || (rt_hit && !MemWrite_ID));
  assign Stall_IF_ID  = hazard;
  assign Bubble_ID_EX = hazard;
  assign id_vld       = id_live && !hazard;

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (hazard) state_nxt = STALL;
      STALL:   state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Forwarding sources as seen after this edge: MEM gets today's EX, WB gets today's MEM
  hazard_match #(.W(REG_W_MAX)) u_a_mem (
    .vld(vld_p0 && rec_p0.regwrite && !rec_p0.memread), .wreg(rec_p0.wreg),
    .src(id_rec.rs), .use_src(id_vld && Uses_Rs_ID), .match(a_mem)
  );
  hazard_match #(.W(REG_W_MAX)) u_a_wb (
    .vld(vld_p1 && rec_p1.regwrite), .wreg(rec_p1.wreg),
    .src(id_rec.rs), .use_src(id_vld && Uses_Rs_ID), .match(a_wb)
  );
  hazard_match #(.W(REG_W_MAX)) u_b_mem (
    .vld(vld_p0 && rec_p0.regwrite && !rec_p0.memread), .wreg(rec_p0.wreg),
    .src(id_rec.rt), .use_src(id_vld && Uses_Rt_ID), .match(b_mem)
  );
  hazard_match #(.W(REG_W_MAX)) u_b_wb (
    .vld(vld_p1 && rec_p1.regwrite), .wreg(rec_p1.wreg),
    .src(id_rec.rt), .use_src(id_vld && Uses_Rt_ID), .match(b_wb)
  );
  hazard_match #(.W(REG_W_MAX)) u_m2m (
    .vld(vld_p1 && rec_p1.memread), .wreg(rec_p1.wreg),
    .src(rec_p0.rt), .use_src(vld_p0 && rec_p0.memwrite), .match(m2m_hit)
  );

  assign fwd_a_nxt = a_mem ? FWD_MEM : (a_wb ? FWD_WB : FWD_REG);
  assign fwd_b_nxt = b_mem ? FWD_MEM : (b_wb ? FWD_WB : FWD_REG);

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      vld_p0             <= 1'b0;
      vld_p1             <= 1'b0;
      vld_p2             <= 1'b0;
      state              <= RUN;
      Forward_A_EX       <= FWD_REG;
      Forward_B_EX       <= FWD_REG;
      Forward_Mem_to_Mem <= 1'b0;
      Stall_Count        <= '0;
    end else begin
      vld_p0             <= id_vld;
      vld_p1             <= vld_p0;
      vld_p2             <= vld_p1;
      state              <= state_nxt;
      Forward_A_EX       <= fwd_a_nxt;
      Forward_B_EX       <= fwd_b_nxt;
      Forward_Mem_to_Mem <= m2m_hit;
      if (Stall_IF_ID) Stall_Count <= sat_inc(Stall_Count);
    end
  end

  always_ff @(posedge Clk) begin
    rec_p0 <= id_rec;
    rec_p1 <= rec_p0;
    rec_p2 <= rec_p1;
  end

  // The WB record and the source fields of older records are kept for
  // visibility; no decision depends on them.
  logic unused_rec;
  assign unused_rec = ^{vld_p2, rec_p2, rec_p1, rec_p0};

endmodule

// File: tb/tb_mem_hazard_unit.sv
// Directed bench for mem_hazard_unit: forwarding, load-use stall, flush,
// reset-in-stall and stall-counter saturation.
module tb_mem_hazard_unit;

  localparam int REG_ADDR_W = 5;
  localparam int COUNT_W    = 4;

  logic                  Clk = 1'b0;
  logic                  Reset_n;
  logic                  Valid_ID, Uses_Rs_ID, Uses_Rt_ID;
  logic                  MemRead_ID, MemWrite_ID, RegWrite_ID, Flush_ID;
  logic [REG_ADDR_W-1:0] Rs_ID, Rt_ID, Write_Reg_ID;
  logic                  Stall_IF_ID, Bubble_ID_EX, Forward_Mem_to_Mem;
  logic [1:0]            Forward_A_EX, Forward_B_EX;
  logic [COUNT_W-1:0]    Stall_Count;

  int n_chk  = 0;
  int n_fail = 0;

  mem_hazard_unit #(.REG_ADDR_W(REG_ADDR_W), .COUNT_W(COUNT_W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Valid_ID(Valid_ID), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID),
    .Uses_Rs_ID(Uses_Rs_ID), .Uses_Rt_ID(Uses_Rt_ID), .MemRead_ID(MemRead_ID),
    .MemWrite_ID(MemWrite_ID), .RegWrite_ID(RegWrite_ID), .Write_Reg_ID(Write_Reg_ID),
    .Flush_ID(Flush_ID), .Stall_IF_ID(Stall_IF_ID), .Bubble_ID_EX(Bubble_ID_EX),
    .Forward_A_EX(Forward_A_EX), .Forward_B_EX(Forward_B_EX),
    .Forward_Mem_to_Mem(Forward_Mem_to_Mem), .Stall_Count(Stall_Count)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Present one ID instruction; settles combinational outputs before returning.
  task automatic drive(input logic v, input int rs, input int rt, input logic urs,
                       input logic urt, input logic mr, input logic mw,
                       input logic rw, input int wr);
    Valid_ID     = v;
    Rs_ID        = REG_ADDR_W'(rs);
    Rt_ID        = REG_ADDR_W'(rt);
    Uses_Rs_ID   = urs;
    Uses_Rt_ID   = urt;
    MemRead_ID   = mr;
    MemWrite_ID  = mw;
    RegWrite_ID  = rw;
    Write_Reg_ID = REG_ADDR_W'(wr);
    #1;
  endtask

  task automatic nop();
    drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  // lw $wr,0($9)
  task automatic lw(input int wr);
    drive(1'b1, 9, wr, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, wr);
  endtask

  // R-type rd,rs,rt
  task automatic rop(input int rd, input int rs, input int rt);
    drive(1'b1, rs, rt, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, rd);
  endtask

  initial begin
    Flush_ID = 1'b0;
    Reset_n  = 1'b0;
    nop();
    tick(); tick(); tick();
    check("rst_stall",  Stall_IF_ID, 0);
    check("rst_bubble", Bubble_ID_EX, 0);
    check("rst_fwd_a",  Forward_A_EX, 0);
    check("rst_fwd_b",  Forward_B_EX, 0);
    check("rst_m2m",    Forward_Mem_to_Mem, 0);
    check("rst_count",  Stall_Count, 0);
    Reset_n = 1'b1;
    tick();

    // lw $8,0($9); sw $8,4($10)
    lw(8);
    tick();
    drive(1'b1, 10, 8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    check("lwsw_no_stall", Stall_IF_ID, 0);
    tick();
    nop();
    check("lwsw_m2m_ex", Forward_Mem_to_Mem, 0);
    check("lwsw_fwd_b",  Forward_B_EX, 0);
    tick();
    check("lwsw_m2m_mem", Forward_Mem_to_Mem, 1);
    tick();
    check("lwsw_m2m_wb", Forward_Mem_to_Mem, 0);
    check("lwsw_count",  Stall_Count, 0);

    // lw $8; add $11,$8,$12
    lw(8);
    tick();
    rop(11, 8, 12);
    check("lu_stall",  Stall_IF_ID, 1);
    check("lu_bubble", Bubble_ID_EX, 1);
    check("lu_count0", Stall_Count, 0);
    tick();
    check("lu_stall_once", Stall_IF_ID, 0);
    check("lu_count1",     Stall_Count, 1);
    check("lu_bub_fwd_a",  Forward_A_EX, 0);
    tick();
    nop();
    check("lu_fwd_a_wb", Forward_A_EX, 1);
    check("lu_fwd_b",    Forward_B_EX, 0);
    tick();

    // add $8,$1,$2; sub $13,$8,$8
    rop(8, 1, 2);
    tick();
    rop(13, 8, 8);
    check("exex_no_stall", Stall_IF_ID, 0);
    tick();
    nop();
    check("exex_fwd_a", Forward_A_EX, 2);
    check("exex_fwd_b", Forward_B_EX, 2);
    tick();

    // add $8; or $20,$1,$2; sub $13,$8,$8
    rop(8, 1, 2);
    tick();
    rop(20, 1, 2);
    tick();
    rop(13, 8, 8);
    tick();
    nop();
    check("wbex_fwd_a", Forward_A_EX, 1);
    check("wbex_fwd_b", Forward_B_EX, 1);
    tick();

    // lw $0; add $11,$0,$0
    lw(0);
    tick();
    rop(11, 0, 0);
    check("r0_no_stall", Stall_IF_ID, 0);
    tick();
    nop();
    check("r0_fwd_a_mem", Forward_A_EX, 0);
    check("r0_fwd_b_mem", Forward_B_EX, 0);
    tick();
    check("r0_fwd_a_wb", Forward_A_EX, 0);
    check("r0_fwd_b_wb", Forward_B_EX, 0);
    check("r0_count",    Stall_Count, 1);

    // lw $8; add $11,$8,$12 flushed; or $21,$11,$0 must not see $11 in flight
    lw(8);
    tick();
    Flush_ID = 1'b1;
    rop(11, 8, 12);
    check("flush_stall",  Stall_IF_ID, 0);
    check("flush_bubble", Bubble_ID_EX, 0);
    tick();
    Flush_ID = 1'b0;
    drive(1'b1, 11, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 21);
    check("flush_count",   Stall_Count, 1);
    check("flush_ex_fwda", Forward_A_EX, 0);
    tick();
    nop();
    check("flush_bubble_fwd", Forward_A_EX, 0);
    tick();

    // Reset asserted while in STALL
    lw(8);
    tick();
    rop(11, 8, 12);
    check("rs_stall", Stall_IF_ID, 1);
    tick();
    Reset_n = 1'b0;
    #1;
    check("rs_stall_forced", Stall_IF_ID, 0);
    tick();
    check("rs_count", Stall_Count, 0);
    check("rs_fwd_a", Forward_A_EX, 0);
    check("rs_fwd_b", Forward_B_EX, 0);
    check("rs_m2m",   Forward_Mem_to_Mem, 0);
    Reset_n = 1'b1;
    #1;
    check("rs_reeval_stall",  Stall_IF_ID, 0);
    check("rs_reeval_bubble", Bubble_ID_EX, 0);
    tick();
    nop();
    check("rs_add_fwd_a", Forward_A_EX, 0);
    tick();

    // 20 load-use pairs: counter saturates at 15
    for (int i = 0; i < 20; i++) begin
      lw(8);
      tick();
      rop(11, 8, 12);
      check($sformatf("sat_stall_%0d", i), Stall_IF_ID, 1);
      tick();
      check($sformatf("sat_count_%0d", i), Stall_Count, (i + 1 > 15) ? 15 : i + 1);
      tick();
    end
    nop();
    tick();
    check("sat_final", Stall_Count, 15);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
